// File: rtl/alu_issue_stage.sv
// alu_issue_stage: MIPS decode to ALU op/operands feeding a 2-entry elastic buffer toward EX.
// Define ALU_ISSUE_FWD_EN to enable EX/MEM and MEM/WB operand forwarding at capture.
module alu_issue_stage #(
  parameter int DEPTH         = 2,
  parameter bit RESET_ILLEGAL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_rs_data,
  input  logic [31:0] in_rt_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_A,
  output logic [31:0] out_B,
  output logic [2:0]  out_ALUOP,
  output logic [4:0]  out_dest,
  output logic        out_illegal,
  input  logic [4:0]  fwd1_reg,
  input  logic [31:0] fwd1_data,
  input  logic        fwd1_en,
  input  logic [4:0]  fwd2_reg,
  input  logic [31:0] fwd2_data,
  input  logic        fwd2_en
);
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [4:0]  dest;
    logic        ill;
  } entry_t;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [2:0] OP_AND = 3'b000, OP_OR = 3'b001, OP_ADD = 3'b010,
                         OP_NOR = 3'b100, OP_SUB = 3'b110, OP_SLT = 3'b111;
  logic [5:0]  opc, fn;
  logic [4:0]  rs, rt, rd;
  logic [31:0] simm, zimm, rs_val, rt_val;
  entry_t      dec, head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic        full, push, pop;
  assign opc  = in_instr[31:26];
  assign rs   = in_instr[25:21];
  assign rt   = in_instr[20:16];
  assign rd   = in_instr[15:11];
  assign fn   = in_instr[5:0];
  assign simm = {{16{in_instr[15]}}, in_instr[15:0]};
  assign zimm = {16'h0000, in_instr[15:0]};
`ifdef ALU_ISSUE_FWD_EN
  assign rs_val = (rs != 5'd0 && fwd1_en && fwd1_reg == rs) ? fwd1_data :
                  (rs != 5'd0 && fwd2_en && fwd2_reg == rs) ? fwd2_data : in_rs_data;
  assign rt_val = (rt != 5'd0 && fwd1_en && fwd1_reg == rt) ? fwd1_data :
                  (rt != 5'd0 && fwd2_en && fwd2_reg == rt) ? fwd2_data : in_rt_data;
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd1_reg, fwd1_data, fwd1_en, fwd2_reg, fwd2_data, fwd2_en};
  assign rs_val = in_rs_data;
  assign rt_val = in_rt_data;
`endif
  always_comb begin
    dec = '{a: rs_val, b: rt_val, op: OP_ADD, dest: 5'd0, ill: 1'b0};
    case (opc)
      6'b000000: begin
        dec.dest = rd;
        case (fn)
          6'b100000, 6'b100001: dec.op = OP_ADD;
          6'b100010, 6'b100011: dec.op = OP_SUB;
          6'b100100:            dec.op = OP_AND;
          6'b100101:            dec.op = OP_OR;
          6'b100111:            dec.op = OP_NOR;
          6'b101010:            dec.op = OP_SLT;
          default:              dec.ill = 1'b1;
        endcase
      end
      6'b001000, 6'b001001, 6'b100011: begin
        dec.b    = simm;
        dec.dest = rt;
      end
      6'b001010: begin
        dec.b    = simm;
        dec.op   = OP_SLT;
        dec.dest = rt;
      end
      6'b001100: begin
        dec.b    = zimm;
        dec.op   = OP_AND;
        dec.dest = rt;
      end
      6'b001101: begin
        dec.b    = zimm;
        dec.op   = OP_OR;
        dec.dest = rt;
      end
      6'b101011: dec.b = simm;
      6'b000100: dec.op = OP_SUB;
      default:   dec.ill = 1'b1;
    endcase
    if (dec.ill) dec = '{a: '0, b: '0, op: OP_ADD, dest: 5'd0, ill: 1'b1};
  end
  assign full      = count_q == CW'(DEPTH);
  assign in_ready  = !full;
  assign out_valid = count_q != '0;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  // head_q doubles as the output register so out_* hold their last value when empty
  always_comb begin
    count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
    head_d  = (pop && full) ? tail_q : (push && (!out_valid || pop)) ? dec : head_q;
    tail_d  = (push && out_valid && !pop) ? dec : tail_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '{a: '0, b: '0, op: OP_AND, dest: 5'd0, ill: RESET_ILLEGAL};
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  assign out_A       = head_q.a;
  assign out_B       = head_q.b;
  assign out_ALUOP   = head_q.op;
  assign out_dest    = head_q.dest;
  assign out_illegal = head_q.ill;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed scenarios plus a randomized queue-based scoreboard for alu_issue_stage.
module tb_alu_issue_stage;
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0, in_rs_data = '0, in_rt_data = '0;
  logic [4:0]  fwd1_reg = '0, fwd2_reg = '0;
  logic [31:0] fwd1_data = '0, fwd2_data = '0;
  logic        fwd1_en = 1'b0, fwd2_en = 1'b0;
  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_A, out_B;
  logic [2:0]  out_ALUOP;
  logic [4:0]  out_dest;
  int total = 0, bad = 0;
`ifdef ALU_ISSUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [4:0]  dest;
    logic        ill;
  } exp_t;
  exp_t q[$];
  exp_t last;
  alu_issue_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_A(out_A), .out_B(out_B), .out_ALUOP(out_ALUOP),
    .out_dest(out_dest), .out_illegal(out_illegal),
    .fwd1_reg(fwd1_reg), .fwd1_data(fwd1_data), .fwd1_en(fwd1_en),
    .fwd2_reg(fwd2_reg), .fwd2_data(fwd2_data), .fwd2_en(fwd2_en)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] rtype(logic [4:0] s, logic [4:0] t, logic [4:0] d, logic [5:0] f);
    return {6'd0, s, t, d, 5'd0, f};
  endfunction
  function automatic logic [31:0] itype(logic [5:0] o, logic [4:0] s, logic [4:0] t, logic [15:0] imm);
    return {o, s, t, imm};
  endfunction
  function automatic logic [31:0] pick(logic [4:0] r, logic [31:0] v);
    if (FWD && r != 0 && fwd1_en && fwd1_reg == r) return fwd1_data;
    if (FWD && r != 0 && fwd2_en && fwd2_reg == r) return fwd2_data;
    return v;
  endfunction
  function automatic exp_t model();
    logic [5:0] o = in_instr[31:26], f = in_instr[5:0];
    logic [4:0] s = in_instr[25:21], t = in_instr[20:16], d = in_instr[15:11];
    logic [31:0] a = pick(s, in_rs_data), rv = pick(t, in_rt_data);
    logic [31:0] sx = 32'($signed(in_instr[15:0])), zx = 32'(in_instr[15:0]);
    exp_t e = '{a: 0, b: 0, op: 3'b010, dest: 0, ill: 1};
    if (o == 0) begin
      if (f == 6'h20 || f == 6'h21) e = '{a, rv, 3'b010, d, 1'b0};
      if (f == 6'h22 || f == 6'h23) e = '{a, rv, 3'b110, d, 1'b0};
      if (f == 6'h24) e = '{a, rv, 3'b000, d, 1'b0};
      if (f == 6'h25) e = '{a, rv, 3'b001, d, 1'b0};
      if (f == 6'h27) e = '{a, rv, 3'b100, d, 1'b0};
      if (f == 6'h2A) e = '{a, rv, 3'b111, d, 1'b0};
    end
    if (o == 6'h08 || o == 6'h09 || o == 6'h23) e = '{a, sx, 3'b010, t, 1'b0};
    if (o == 6'h0A) e = '{a, sx, 3'b111, t, 1'b0};
    if (o == 6'h0C) e = '{a, zx, 3'b000, t, 1'b0};
    if (o == 6'h0D) e = '{a, zx, 3'b001, t, 1'b0};
    if (o == 6'h2B) e = '{a, sx, 3'b010, 5'd0, 1'b0};
    if (o == 6'h04) e = '{a, rv, 3'b110, 5'd0, 1'b0};
    return e;
  endfunction
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    total++; if ({out_A, out_B} !== 64'h0) begin bad++; $display("FAIL reset_ab got=%h_%h exp=0", out_A, out_B); end
    total++; if ({out_ALUOP, out_dest, out_illegal} !== 9'h0) begin bad++; $display("FAIL reset_ctl got=%b/%0d/%b exp=000/0/0", out_ALUOP, out_dest, out_illegal); end
  endtask
  task automatic test_add();
    out_ready = 1'b1; in_valid = 1'b1;
    in_instr = rtype(5'd1, 5'd2, 5'd3, 6'h20); in_rs_data = 32'd5; in_rt_data = 32'd7;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b exp=1", out_valid); end
    total++; if ({out_A, out_B} !== {32'd5, 32'd7}) begin bad++; $display("FAIL add_ab got=%h_%h exp=5_7", out_A, out_B); end
    total++; if ({out_ALUOP, out_dest} !== {3'b010, 5'd3}) begin bad++; $display("FAIL add_op got=%b/%0d exp=010/3", out_ALUOP, out_dest); end
    tick();
    total++; if (out_valid !== 1'b0 || out_A !== 32'd5) begin bad++; $display("FAIL add_hold got=%b/%h exp=0/5", out_valid, out_A); end
  endtask
  task automatic test_imm();
    out_ready = 1'b1; in_valid = 1'b1;
    in_instr = itype(6'h08, 5'd1, 5'd4, 16'hFFFF); in_rs_data = 32'h10;
    tick();
    total++; if ({out_A, out_B, out_ALUOP, out_dest} !== {32'h10, 32'hFFFFFFFF, 3'b010, 5'd4}) begin bad++; $display("FAIL addi got=%h/%h/%b/%0d exp=10/ffffffff/010/4", out_A, out_B, out_ALUOP, out_dest); end
    in_instr = itype(6'h0D, 5'd1, 5'd6, 16'h8000);
    tick();
    in_valid = 1'b0;
    total++; if ({out_B, out_ALUOP, out_dest} !== {32'h00008000, 3'b001, 5'd6}) begin bad++; $display("FAIL ori got=%h/%b/%0d exp=00008000/001/6", out_B, out_ALUOP, out_dest); end
    tick();
  endtask
  task automatic test_back_to_back();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = rtype(5'd1, 5'd2, 5'd3, 6'h20);
    in_rs_data = 32'd1;
    tick();
    in_rs_data = 32'd2;
    tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_full got=%b exp=0", in_ready); end
    in_rs_data = 32'd3;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if ({out_valid, in_ready, out_A} !== {2'b10, 32'd1}) begin bad++; $display("FAIL b2b_stall got=%b/%b/%h exp=1/0/1", out_valid, in_ready, out_A); end
    end
    out_ready = 1'b1;
    tick();
    total++; if (out_A !== 32'd2) begin bad++; $display("FAIL b2b_second got=%h exp=2", out_A); end
    tick();
    in_valid = 1'b0;
    total++; if (out_A !== 32'd3 || out_valid !== 1'b1) begin bad++; $display("FAIL b2b_third got=%h/%b exp=3/1", out_A, out_valid); end
    tick();
    total++; if (out_valid !== 1'b0 || out_A !== 32'd3) begin bad++; $display("FAIL b2b_drain got=%b/%h exp=0/3", out_valid, out_A); end
  endtask
  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = rtype(5'd1, 5'd2, 5'd3, 6'h20);
    in_rs_data = 32'hA;
    tick();
    in_rs_data = 32'hB;
    tick();
    flush = 1'b1; in_rs_data = 32'hC;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL flush_full got=%b/%b exp=0/1", out_valid, in_ready); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_leak got=%b exp=0", out_valid); end
    flush = 1'b1; in_valid = 1'b1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b exp=1", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_empty got=%b exp=0", out_valid); end
    out_ready = 1'b1;
  endtask
  task automatic test_illegal();
    out_ready = 1'b1; in_valid = 1'b1;
    in_instr = {6'h3F, 26'h3ABCDEF}; in_rs_data = 32'h1234; in_rt_data = 32'h5678;
    tick();
    in_valid = 1'b0;
    total++; if ({out_valid, out_illegal, out_ALUOP} !== {2'b11, 3'b010}) begin bad++; $display("FAIL ill_ctl got=%b/%b/%b exp=1/1/010", out_valid, out_illegal, out_ALUOP); end
    total++; if ({out_A, out_B, out_dest} !== 69'h0) begin bad++; $display("FAIL ill_data got=%h/%h/%0d exp=0/0/0", out_A, out_B, out_dest); end
    tick();
  endtask
  task automatic test_fwd();
    logic [31:0] ea;
    out_ready = 1'b1; in_valid = 1'b1;
    in_instr = rtype(5'd4, 5'd5, 5'd7, 6'h22); in_rs_data = 32'h33; in_rt_data = 32'h44;
    fwd1_reg = 5'd4; fwd1_data = 32'h11; fwd1_en = 1'b1;
    fwd2_reg = 5'd4; fwd2_data = 32'h22; fwd2_en = 1'b1;
    ea = FWD ? 32'h11 : 32'h33;
    tick();
    total++; if ({out_A, out_B, out_ALUOP} !== {ea, 32'h44, 3'b110}) begin bad++; $display("FAIL fwd_rs got=%h/%h/%b exp=%h/44/110", out_A, out_B, out_ALUOP, ea); end
    in_instr = rtype(5'd0, 5'd5, 5'd7, 6'h22); fwd1_reg = 5'd0; fwd2_reg = 5'd5;
    ea = FWD ? 32'h22 : 32'h44;
    tick();
    in_valid = 1'b0; fwd1_en = 1'b0; fwd2_en = 1'b0;
    total++; if ({out_A, out_B} !== {32'h33, ea}) begin bad++; $display("FAIL fwd_zero got=%h/%h exp=33/%h", out_A, out_B, ea); end
    tick();
  endtask
  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = rtype(5'd1, 5'd2, 5'd3, 6'h20); in_rs_data = 32'h9;
    tick();
    tick();
    rst = 1'b1; in_valid = 1'b0;
    tick();
    rst = 1'b0;
    total++; if ({out_valid, in_ready, out_A} !== {2'b01, 32'h0}) begin bad++; $display("FAIL rst_mid got=%b/%b/%h exp=0/1/0", out_valid, in_ready, out_A); end
    out_ready = 1'b1;
  endtask
  task automatic test_random();
    logic [5:0] iops[8] = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04};
    logic [5:0] rfns[8] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A};
    int errs = 0;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
    q.delete();
    last = '0;
    for (int c = 0; c < 600; c++) begin
      exp_t h, e;
      bit push, pop;
      h = (q.size() != 0) ? q[0] : last;
      total++; if (out_valid !== (q.size() != 0)) begin bad++; errs++; if (errs < 10) $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, out_valid, q.size() != 0); end
      total++; if (in_ready !== (q.size() < 2)) begin bad++; errs++; if (errs < 10) $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, in_ready, q.size() < 2); end
      total++; if ({out_A, out_B, out_ALUOP, out_dest, out_illegal} !== h) begin bad++; errs++; if (errs < 10) $display("FAIL rnd_head cyc=%0d got=%h/%h/%b/%0d/%b exp=%h/%h/%b/%0d/%b", c, out_A, out_B, out_ALUOP, out_dest, out_illegal, h.a, h.b, h.op, h.dest, h.ill); end
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 19) == 0;
      in_instr = $urandom;
      in_instr[25:21] = 5'($urandom_range(0, 3));
      in_instr[20:16] = 5'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: in_instr[31:26] = iops[$urandom_range(0, 7)];
        1: in_instr = {6'd0, in_instr[25:6], rfns[$urandom_range(0, 7)]};
        2: in_instr[31:26] = 6'd0;
        default: ;
      endcase
      in_rs_data = $urandom; in_rt_data = $urandom;
      fwd1_reg = 5'($urandom_range(0, 3)); fwd1_data = $urandom; fwd1_en = 1'($urandom);
      fwd2_reg = 5'($urandom_range(0, 3)); fwd2_data = $urandom; fwd2_en = 1'($urandom);
      push = in_valid && q.size() < 2 && !flush;
      pop = q.size() != 0 && out_ready && !flush;
      e = model();
      tick();
      if (flush) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (push) q.push_back(e);
      end
      if (q.size() != 0) last = q[0];
    end
    in_valid = 1'b0; flush = 1'b0; fwd1_en = 1'b0; fwd2_en = 1'b0;
  endtask
  initial begin
    test_reset();
    test_add();
    test_imm();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_fwd();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
